dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache between the CPU MEM stage and DataMemory.
//  - CPU side: 32-bit word access.
//  - Memory side: this block is the initiator of the DataMemory enable/write/ack protocol.
//  - Transfers are 256-bit lines; a miss stalls the pipeline until the line is resident.
// PARAMETERS
//  NUM_LINES  32   lines in cache; index width = log2(NUM_LINES) = 5
//  LINE_W     256  line width in bits (8 words); offset = addr[4:0], word select = addr[4:2]
//  ADDR_W     32   address width; tag = addr[31:10] (22 bits at defaults)
// PORTS
//  clock_i       in   1    clock; all state changes on rising edge
//  rst_i         in   1    reset; synchronous, active-low
//  p1_req_i      in   1    CPU access valid (MemRead | MemWrite)
//  p1_write_i    in   1    1 = store, 0 = load
//  p1_addr_i     in   32   byte address; held stable by CPU while p1_stall_o = 1
//  p1_data_i     in   32   store data
//  p1_data_o     out  32   load data; valid when p1_req_i & ~p1_stall_o
//  p1_stall_o    out  1    1 = access not complete, CPU must freeze
//  mem_enable_o  out  1    memory request; high only in states WB and RD
//  mem_write_o   out  1    1 in WB, 0 otherwise
//  mem_addr_o    out  32   line address, low 5 bits always 0
//  mem_data_o    out  256  victim line during WB
//  mem_ack_i     in   1    memory completion, single-cycle pulse
//  mem_data_i    in   256  read line; valid in the cycle AFTER mem_ack_i
// BEHAVIOUR
//  Reset (rst_i = 0 at an edge):
//   - state = IDLE; all valid and dirty bits cleared.
//   - Outputs: mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, p1_stall_o = 0, p1_data_o = 0.
//   - Applies mid-transaction: the in-flight request is abandoned. The bench flushes DataMemory in the same cycle.
//  Hit = valid[idx] & (tag[idx] == p1_addr_i tag); combinational.
//  p1_stall_o = p1_req_i & ~(state == IDLE & hit).
//  Read hit: p1_data_o = line[idx] word addr[4:2], same cycle, zero stall.
//  Write hit: at the edge, merge p1_data_i into word addr[4:2]; set dirty[idx].
//  FSM states: IDLE, WB, GAP, RD, FILL. mem_enable_o decoded from the state register.
//   - IDLE -> WB    on req & ~hit & valid & dirty
//   - IDLE -> RD    on req & ~hit & ~(valid & dirty)
//   - WB -> GAP     on mem_ack_i; victim line now stored. GAP forces one enable-low cycle so DataMemory sees IDLE.
//   - GAP -> RD     unconditional
//   - RD -> FILL    on mem_ack_i
//   - FILL -> IDLE  unconditional. In FILL: line <= mem_data_i; tag <= new tag; valid = 1; dirty = 0.
//   - The original access then retires in IDLE as a hit (a write sets dirty there).
//  Addresses: WB mem_addr_o = {old_tag, idx, 5'b0}; RD mem_addr_o = {new_tag, idx, 5'b0}.
//   - mem_addr_o and mem_data_o are held constant for the whole WB/RD state.
//  Latency with a 10-count DataMemory (ack 10 cycles after enable is first sampled):
//   - hit: 0 stall cycles
//   - clean miss: 13 stall cycles (miss cycle + 11 in RD + FILL)
//   - dirty miss: 25 stall cycles
//  Boundaries:
//   - mem_ack_i outside WB/RD is ignored.
//   - p1_req_i = 0 in IDLE: no state change, stall 0.
//   - p1_req_i dropping during WB/RD/FILL: the fill still completes; nothing is written from p1 side.
//   - Back-to-back misses: enable is always low for at least 1 cycle between transactions (FILL/IDLE/GAP).
//   - Index conflict (same idx, different tag) evicts; the same tag always hits.
// STRUCTURE
//  Package dcache_pkg:
//   - state enum (IDLE/WB/GAP/RD/FILL)
//   - TAG_W, IDX_W, OFF_W, WORD_SEL_W localparams
//   - typedef for {valid, dirty, tag} entry
//  Sub-module dcache_sram:
//   - tag/valid/dirty/data arrays, one synchronous write port, asynchronous read by index
//   - sync active-low clear of valid/dirty
//  Top holds the FSM, hit compare, word merge/select, and memory-side muxes.
// TESTING
//  1. Cold read 0x0000_0040 after reset: stall 13 cycles.
//     - mem_addr_o = 0x40, mem_write_o = 0.
//     - Then p1_data_o = memory[2] word 0.
//  2. Write 0xDEADBEEF to 0x44, then read 0x44:
//     - Write: 13-cycle stall (allocate), then 0-stall read returning 0xDEADBEEF.
//     - dirty[2] = 1.
//  3. After 2, read 0x444 (same idx 2, different tag): 25-cycle stall.
//     - WB at mem_addr_o = 0x40 with word1 = 0xDEADBEEF.
//     - Then RD at 0x440.
//  4. Read hit 0x48 repeated for 4 cycles: p1_stall_o = 0 every cycle; mem_enable_o never asserted.
//  5. rst_i low during RD (cycle 5 of a miss), DataMemory flushed together:
//     - Next cycle mem_enable_o = 0, state IDLE.
//     - Re-request misses again; 13-cycle stall.
//  6. Check enable low for exactly 1 cycle (GAP) between WB ack and RD enable on a dirty miss.

Source files
------------

// File: rtl/dcache_pkg.sv
// Geometry, FSM state encoding and tag-array entry layout for the direct-mapped L1 data cache.
// Declarations only: no latency or flow-control behaviour of its own.
package dcache_pkg;
    localparam int NUM_LINES  = 32;
    localparam int LINE_W     = 256;
    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int IDX_W      = $clog2(NUM_LINES);
    localparam int OFF_W      = $clog2(LINE_W / 8);
    localparam int WORD_SEL_W = OFF_W - 2;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_GAP,
        ST_RD,
        ST_FILL
    } state_e;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } entry_t;

    function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_SEL_W-1:0] sel);
        return line[{sel, 5'b00000} +: WORD_W];
    endfunction

    function automatic logic [LINE_W-1:0] put_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_SEL_W-1:0] sel,
                                                   input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] res;
        res = line;
        res[{sel, 5'b00000} +: WORD_W] = word;
        return res;
    endfunction
endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read by index, one synchronous write port.
// Write lands at the rising edge; reset clears valid/dirty only; no backpressure.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clock_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output entry_t            rd_entry_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  entry_t            wr_entry_i,
    input  logic [LINE_W-1:0] wr_line_i
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
            dirty_q[wr_idx_i] <= wr_entry_i.dirty;
        end
    end

    // Tag and data need no reset: they are meaningless while valid is clear.
    always_ff @(posedge clock_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_entry_i.tag;
            data_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_entry_o = '{valid: valid_q[rd_idx_i], dirty: dirty_q[rd_idx_i], tag: tag_q[rd_idx_i]};
    assign rd_line_o  = data_q[rd_idx_i];
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache; hits complete in the same cycle.
// Misses stall the CPU through optional write-back (WB, GAP) then line read (RD, FILL).
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clock_i,
    input  logic              rst_i,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i
);
    state_e           state_q, state_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;

    logic [TAG_W-1:0]      p1_tag;
    logic [IDX_W-1:0]      p1_idx;
    logic [WORD_SEL_W-1:0] p1_word;
    logic                  unused_addr_bits;

    logic [IDX_W-1:0]  rd_idx;
    entry_t            rd_entry;
    logic [LINE_W-1:0] rd_line;
    logic              hit;
    logic              idle_hit;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    entry_t            wr_entry;
    logic [LINE_W-1:0] wr_line;

    assign p1_tag           = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p1_idx           = p1_addr_i[OFF_W +: IDX_W];
    assign p1_word          = p1_addr_i[OFF_W-1:2];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // Outside IDLE the arrays are looked up by the latched miss index, so the
    // victim tag/line stay constant even if the CPU drops or changes its request.
    assign rd_idx   = (state_q == ST_IDLE) ? p1_idx : miss_idx_q;
    assign hit      = rd_entry.valid & (rd_entry.tag == p1_tag);
    assign idle_hit = (state_q == ST_IDLE) & hit;

    assign p1_stall_o = p1_req_i & ~idle_hit;
    assign p1_data_o  = (p1_req_i & idle_hit) ? get_word(rd_line, p1_word) : '0;

    dcache_sram u_sram (
        .clock_i    (clock_i),
        .rst_i      (rst_i),
        .rd_idx_i   (rd_idx),
        .rd_entry_o (rd_entry),
        .rd_line_o  (rd_line),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wr_idx),
        .wr_entry_i (wr_entry),
        .wr_line_i  (wr_line)
    );

    always_ff @(posedge clock_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            miss_tag_q <= '0;
            miss_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            miss_tag_q <= miss_tag_d;
            miss_idx_q <= miss_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        miss_tag_d   = miss_tag_q;
        miss_idx_d   = miss_idx_q;
        wr_en        = 1'b0;
        wr_idx       = p1_idx;
        wr_entry     = rd_entry;
        wr_line      = rd_line;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;

        case (state_q)
            ST_IDLE: begin
                if (p1_req_i) begin
                    if (hit) begin
                        if (p1_write_i) begin
                            wr_en          = 1'b1;
                            wr_entry.dirty = 1'b1;
                            wr_line        = put_word(rd_line, p1_word, p1_data_i);
                        end
                    end else begin
                        miss_tag_d = p1_tag;
                        miss_idx_d = p1_idx;
                        state_d    = (rd_entry.valid & rd_entry.dirty) ? ST_WB : ST_RD;
                    end
                end
            end
            ST_WB: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {rd_entry.tag, miss_idx_q, {OFF_W{1'b0}}};
                mem_data_o   = rd_line;
                if (mem_ack_i) state_d = ST_GAP;
            end
            // One enable-low cycle lets DataMemory return to idle before the read.
            ST_GAP: state_d = ST_RD;
            ST_RD: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
                if (mem_ack_i) state_d = ST_FILL;
            end
            ST_FILL: begin
                wr_en    = 1'b1;
                wr_idx   = miss_idx_q;
                wr_entry = '{valid: 1'b1, dirty: 1'b0, tag: miss_tag_q};
                wr_line  = mem_data_i;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench: 10-count DataMemory model plus scoreboards for CPU completions and memory transactions.
module tb_dcache_controller;
    logic         clock_i = 1'b0;
    logic         rst_i;
    logic         p1_req_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_ack_i;
    logic [255:0] mem_data_i;

    always #5 clock_i = ~clock_i;

    dcache_controller dut (
        .clock_i      (clock_i),
        .rst_i        (rst_i),
        .p1_req_i     (p1_req_i),
        .p1_write_i   (p1_write_i),
        .p1_addr_i    (p1_addr_i),
        .p1_data_i    (p1_data_i),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_ack_i    (mem_ack_i),
        .mem_data_i   (mem_data_i)
    );

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          stall;
    } acc_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] word1;
        int          gap;
    } mexp_t;

    acc_t   acc_q[$];
    mexp_t  mem_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     en_cnt = 0;
    bit     spur = 0;
    logic [255:0] mem [128];

    function automatic logic [31:0] pat(input int line, input int w);
        return 32'hA000_0000 | (32'(line) << 8) | 32'(w);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push_mem(input logic wr, input logic [31:0] addr, input logic [31:0] w1, input int gap);
        mexp_t m;
        m.wr = wr; m.addr = addr; m.word1 = w1; m.gap = gap;
        mem_q.push_back(m);
    endtask

    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [31:0] exp, input int st, input bit keep);
        acc_t e;
        bit   done;
        @(posedge clock_i); #1;
        e.wr = wr; e.data = exp; e.stall = st;
        acc_q.push_back(e);
        p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = addr; p1_data_i = wdat;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock_i);
            if (!p1_stall_o) done = 1'b1;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL access_timeout: addr %h still stalled after 100 cycles, expected completion", addr);
            void'(acc_q.pop_back());
        end
        if (!keep || !done) begin
            @(posedge clock_i); #1;
            p1_req_i = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clock_i); #1;
        rst_i = 1'b0; p1_req_i = 1'b0;
        @(posedge clock_i); #1;
        rst_i = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clock_i);
        chk({tag, "_mem_enable"}, 32'(mem_enable_o), 32'd0);
        chk({tag, "_mem_write"},  32'(mem_write_o),  32'd0);
        chk({tag, "_mem_addr"},   mem_addr_o,        32'd0);
        chk({tag, "_p1_stall"},   32'(p1_stall_o),   32'd0);
        chk({tag, "_p1_data"},    p1_data_o,         32'd0);
    endtask

    // CPU-side monitor: counts stall cycles and checks each completed access.
    initial begin
        int   stall_cnt;
        acc_t e;
        stall_cnt = 0;
        forever begin
            @(negedge clock_i);
            if (!rst_i || !p1_req_i) begin
                stall_cnt = 0;
            end else if (p1_stall_o) begin
                stall_cnt++;
            end else begin
                if (acc_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_completion: addr %h completed, expected none", p1_addr_i);
                end else begin
                    e = acc_q.pop_front();
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    if (!e.wr) chk("load_data", p1_data_o, e.data);
                end
                stall_cnt = 0;
            end
        end
    end

    // DataMemory model (ack 10 cycles after enable first seen) and memory-side monitor.
    initial begin
        int          cnt, low_run, tx_gap, rd_line;
        bit          in_tx, pend_rd;
        logic [31:0] tx_addr;
        mexp_t       me;
        cnt = 0; low_run = 0; tx_gap = 0; rd_line = 0;
        in_tx = 0; pend_rd = 0; tx_addr = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        forever begin
            @(posedge clock_i); #2;
            mem_ack_i = 1'b0;
            if (!rst_i) begin
                cnt = 0; in_tx = 0; pend_rd = 0;
                continue;
            end
            if (pend_rd) begin
                mem_data_i = mem[rd_line];
                pend_rd = 0;
            end
            if (spur) begin
                mem_ack_i = 1'b1;
                spur = 0;
            end
            if (mem_enable_o) begin
                en_cnt++;
                if (!in_tx) begin
                    in_tx = 1; tx_addr = mem_addr_o; tx_gap = low_run;
                end else begin
                    chk("mem_addr_hold", mem_addr_o, tx_addr);
                end
                low_run = 0;
                if (cnt == 10) begin
                    mem_ack_i = 1'b1; cnt = 0; in_tx = 0;
                    if (mem_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL unexpected_mem_tx: addr %h write %0d, expected none", mem_addr_o, mem_write_o);
                    end else begin
                        me = mem_q.pop_front();
                        chk("mem_write", 32'(mem_write_o), 32'(me.wr));
                        chk("mem_addr", mem_addr_o, me.addr);
                        if (me.gap != 0) chk("enable_gap", 32'(tx_gap), 32'(me.gap));
                        if (me.wr) chk("wb_word1", mem_data_o[63:32], me.word1);
                    end
                    if (mem_write_o) mem[mem_addr_o[11:5]] = mem_data_o;
                    else begin
                        pend_rd = 1; rd_line = 32'(mem_addr_o[11:5]);
                    end
                end else begin
                    cnt++;
                end
            end else begin
                low_run++;
                cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < 128; l++)
            for (int w = 0; w < 8; w++)
                mem[l][w*32 +: 32] = pat(l, w);
        rst_i = 1'b0; p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        repeat (2) @(posedge clock_i);
        #1 rst_i = 1'b1;
        check_reset_outputs("reset");

        // Cold read miss.
        push_mem(1'b0, 32'h40, 32'h0, 0);
        access(1'b0, 32'h40, 32'h0, pat(2, 0), 13, 1'b0);

        // Write-allocate then read hit.
        do_reset();
        push_mem(1'b0, 32'h40, 32'h0, 0);
        access(1'b1, 32'h44, 32'hDEADBEEF, 32'h0, 13, 1'b0);
        access(1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 0, 1'b0);

        // Index conflict on a dirty line: write-back, one-cycle gap, then read.
        push_mem(1'b1, 32'h40, 32'hDEADBEEF, 0);
        push_mem(1'b0, 32'h440, 32'h0, 1);
        access(1'b0, 32'h444, 32'h0, pat(34, 1), 25, 1'b0);

        // Re-fetch the written-back line; then back-to-back hits with a stray ack.
        push_mem(1'b0, 32'h40, 32'h0, 0);
        access(1'b0, 32'h48, 32'h0, pat(2, 2), 13, 1'b0);
        access(1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        en_cnt = 0;
        spur = 1;
        access(1'b0, 32'h48, 32'h0, pat(2, 2), 0, 1'b1);
        access(1'b0, 32'h48, 32'h0, pat(2, 2), 0, 1'b1);
        access(1'b0, 32'h48, 32'h0, pat(2, 2), 0, 1'b1);
        access(1'b0, 32'h48, 32'h0, pat(2, 2), 0, 1'b0);
        chk("hit_window_enables", 32'(en_cnt), 32'd0);

        // Reset in the middle of RD abandons the fill.
        @(posedge clock_i); #1;
        p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h60;
        repeat (5) @(posedge clock_i);
        #1;
        rst_i = 1'b0; p1_req_i = 1'b0;
        @(posedge clock_i); #1;
        rst_i = 1'b1;
        check_reset_outputs("midrd_reset");
        push_mem(1'b0, 32'h60, 32'h0, 0);
        access(1'b0, 32'h60, 32'h0, pat(3, 0), 13, 1'b0);

        // Store request dropped mid-miss: fill completes clean, store is not merged.
        push_mem(1'b0, 32'h800, 32'h0, 0);
        @(posedge clock_i); #1;
        p1_req_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h800; p1_data_i = 32'h1234_5678;
        repeat (3) @(posedge clock_i);
        #1 p1_req_i = 1'b0;
        repeat (20) @(posedge clock_i);
        access(1'b0, 32'h800, 32'h0, pat(64, 0), 0, 1'b0);
        push_mem(1'b0, 32'hC00, 32'h0, 0);
        access(1'b0, 32'hC00, 32'h0, pat(96, 0), 13, 1'b0);

        repeat (30) @(posedge clock_i);
        chk("cpu_queue_drained", 32'(acc_q.size()), 32'd0);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
